// File: rtl/elastic_pipeline_pkg.sv
// Shared helpers for the elastic pipeline: occupancy counter sizing.
package elastic_pipeline_pkg;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipeline_pipe_stage.sv
// One pipeline stage: data register plus valid bit with load enable and flush clear.
module pipe_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_data,
  output logic            q_valid,
  output logic [XLEN-1:0] q_data
);

  // Data only captures real beats; an empty stage keeps its last contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      if (d_valid) begin
        q_data <= d_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Bubble-collapsing valid/ready delay line of DEPTH stages with stall, flush and occupancy.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = occ_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] can_take;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] nxt_valid;
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [XLEN-1:0]  src_data [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;
  logic             go;

  assign go = !stall && !flush;

  // A stage can take new contents if any stage at or after it is empty, or the consumer drains.
  always_comb begin : ready_chain
    logic room;
    room     = out_ready;
    can_take = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      room        = room | !valid_q[i];
      can_take[i] = room;
    end
  end

  assign load = can_take & {DEPTH{go}};

  always_comb begin : source_select
    src_valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      src_data[i] = '0;
    end
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  genvar g;
  for (g = 0; g < int'(DEPTH); g++) begin : g_stage
    pipe_stage #(
      .XLEN(XLEN)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .clear   (flush),
      .load    (load[g]),
      .d_valid (src_valid[g]),
      .d_data  (src_data[g]),
      .q_valid (valid_q[g]),
      .q_data  (data_q[g])
    );
  end

  // Occupancy tracks the valid bits the stages will hold after this edge.
  always_comb begin : occ_next
    nxt_valid = '0;
    occ_nxt   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      nxt_valid[i] = load[i] ? src_valid[i] : valid_q[i];
    end
    if (flush) begin
      nxt_valid = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_nxt = occ_nxt + OCC_W'(nxt_valid[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_nxt;
    end
  end

  assign in_ready  = !reset && go && can_take[0];
  assign out_valid = !reset && go && valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed self-checking bench for elastic_pipeline (DEPTH=4/XLEN=32, plus DEPTH=1 and 7 at XLEN=8).
module tb_elastic_pipeline;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        stall, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  occupancy;

  logic        s_flush, s_in_valid, s_out_ready;
  logic [7:0]  s_in_data;
  logic        d1_in_ready, d1_out_valid, d7_in_ready, d7_out_valid;
  logic [7:0]  d1_out_data, d7_out_data;
  logic [0:0]  d1_occ;
  logic [2:0]  d7_occ;

  int          tests = 0;
  int          fails = 0;
  int          acc_cnt = 0;
  logic [31:0] got[$];

  elastic_pipeline #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  elastic_pipeline #(.XLEN(8), .DEPTH(1)) dut_d1 (
    .clock(clock), .reset(reset), .stall(1'b0), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(d1_in_ready), .in_data(s_in_data),
    .out_valid(d1_out_valid), .out_ready(s_out_ready), .out_data(d1_out_data),
    .occupancy(d1_occ)
  );

  elastic_pipeline #(.XLEN(8), .DEPTH(7)) dut_d7 (
    .clock(clock), .reset(reset), .stall(1'b0), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(d7_in_ready), .in_data(s_in_data),
    .out_valid(d7_out_valid), .out_ready(s_out_ready), .out_data(d7_out_data),
    .occupancy(d7_occ)
  );

  // Records handshakes of the main DUT in the cycle, then advances one clock.
  task automatic tick();
    #1;
    if (out_valid && out_ready) got.push_back(out_data);
    if (in_valid && in_ready) acc_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (d7_occ !== 3'd0) begin fails++; $display("FAIL reset_d7_occ got %0d want 0", d7_occ); end
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    got.delete();
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_lat_n1 got %b want 0", out_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (out_valid !== (k == 3)) begin fails++; $display("FAIL reset_lat_n%0d out_valid got %b want %b", k + 1, out_valid, (k == 3)); end
    end
    tests++; if (out_data !== 32'hA5A5_0001) begin fails++; $display("FAIL reset_first_beat got %h want a5a50001", out_data); end
    tick();
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_drain_occ got %0d want 0", occupancy); end
    tests++; if (got.size() != 1) begin fails++; $display("FAIL reset_drain_count got %0d want 1", got.size()); end
  endtask

  task automatic test_stream();
    logic [31:0] exp[$];
    got.delete(); acc_cnt = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom;
      exp.push_back(in_data);
      if (i == 50) begin
        tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL stream_occ got %0d want 4", occupancy); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_full_in_ready got %b want 1", in_ready); end
      end
      tick();
    end
    tests++; if (acc_cnt != 100) begin fails++; $display("FAIL stream_accepts got %0d want 100", acc_cnt); end
    tests++; if (got.size() != 96) begin fails++; $display("FAIL stream_latency_count got %0d want 96", got.size()); end
    in_valid = 1'b0;
    repeat (4) tick();
    tests++;
    if (got.size() != 100) begin
      fails++; $display("FAIL stream_total got %0d want 100", got.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        tests++;
        if (got[i] !== exp[i]) begin fails++; $display("FAIL stream_beat%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    got.delete(); acc_cnt = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + 32'(i);
      tick();
    end
    tests++; if (acc_cnt != 4) begin fails++; $display("FAIL bp_accepts got %0d want 4", acc_cnt); end
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_occ got %0d want 4", occupancy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h100) begin fails++; $display("FAIL bp_head got %b/%h want 1/100", out_valid, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    tests++;
    if (got.size() != 4) begin
      fails++; $display("FAIL bp_drain_count got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got[i] !== 32'h100 + 32'(i)) begin fails++; $display("FAIL bp_drain%0d got %h want %h", i, got[i], 32'h100 + 32'(i)); end
      end
    end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL bp_empty_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_bubble();
    got.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'h2; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL bubble_occ got %0d want 2", occupancy); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin fails++; $display("FAIL bubble_head got %b/%h want 1/1", out_valid, out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin fails++; $display("FAIL bubble_collapsed got %b/%h want 1/2", out_valid, out_data); end
    tick();
    tests++; if (got.size() != 2 || got[0] !== 32'h1 || got[1] !== 32'h2) begin fails++; $display("FAIL bubble_order got %0d beats", got.size()); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL bubble_empty_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_stall();
    got.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h31 + 32'(i);
      tick();
    end
    stall = 1'b1; in_data = 32'hDEAD;
    #1;
    for (int k = 0; k < 5; k++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready_c%0d got %b want 0", k, in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_out_valid_c%0d got %b want 0", k, out_valid); end
      tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL stall_occ_c%0d got %0d want 3", k, occupancy); end
      tick();
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (6) tick();
    tests++;
    if (got.size() != 3 || got[0] !== 32'h31 || got[1] !== 32'h32 || got[2] !== 32'h33) begin
      fails++; $display("FAIL stall_resume got %0d beats want 31,32,33", got.size());
    end
  endtask

  task automatic test_flush();
    got.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h41 + 32'(i);
      tick();
    end
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
    flush = 1'b1; in_data = 32'hF1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (out_valid !== (k == 3)) begin fails++; $display("FAIL flush_lat_n%0d out_valid got %b want %b", k + 1, out_valid, (k == 3)); end
    end
    tick(); tick();
    tests++;
    if (got.size() != 1 || got[0] !== 32'h55) begin
      fails++; $display("FAIL flush_leak got %0d beats want only 55", got.size());
    end
  endtask

  task automatic test_flush_small();
    int lat1, lat7, stray;
    s_out_ready = 1'b1; s_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in_data = 8'h11 + 8'(i);
      tick();
    end
    tests++; if (d1_occ !== 1'b1) begin fails++; $display("FAIL d1_pre_occ got %0d want 1", d1_occ); end
    tests++; if (d7_occ !== 3'd3) begin fails++; $display("FAIL d7_pre_occ got %0d want 3", d7_occ); end
    s_flush = 1'b1; s_in_data = 8'hEE;
    #1;
    tests++; if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b0) begin fails++; $display("FAIL d1_flush_hs got %b/%b want 0/0", d1_out_valid, d1_in_ready); end
    tests++; if (d7_out_valid !== 1'b0 || d7_in_ready !== 1'b0) begin fails++; $display("FAIL d7_flush_hs got %b/%b want 0/0", d7_out_valid, d7_in_ready); end
    tick();
    s_flush = 1'b0; s_in_valid = 1'b0;
    #1;
    tests++; if (d1_occ !== 1'b0) begin fails++; $display("FAIL d1_flush_occ got %0d want 0", d1_occ); end
    tests++; if (d7_occ !== 3'd0) begin fails++; $display("FAIL d7_flush_occ got %0d want 0", d7_occ); end
    s_in_valid = 1'b1; s_in_data = 8'h77;
    tick();
    s_in_valid = 1'b0;
    lat1 = 0; lat7 = 0; stray = 0;
    for (int k = 1; k <= 10; k++) begin
      if (d1_out_valid) begin
        if (d1_out_data !== 8'h77) stray++;
        else if (lat1 == 0) lat1 = k;
      end
      if (d7_out_valid) begin
        if (d7_out_data !== 8'h77) stray++;
        else if (lat7 == 0) lat7 = k;
      end
      tick();
    end
    tests++; if (lat1 != 1) begin fails++; $display("FAIL d1_latency got %0d want 1", lat1); end
    tests++; if (lat7 != 7) begin fails++; $display("FAIL d7_latency got %0d want 7", lat7); end
    tests++; if (stray != 0) begin fails++; $display("FAIL small_flush_leak got %0d stray beats want 0", stray); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_stall();
    test_flush();
    test_flush_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
